// File: rtl/imm_mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// imm_mc_ctrl_if
// Bundle of the signals between the multicycle controller and the datapath.
// The slave modport is the controller view: it receives the instruction fields
// and the condition result, and drives the datapath strobes and selects.
// The master modport is the datapath view of the same signals.
// -----------------------------------------------------------------------------
interface imm_mc_ctrl_if;

    // Instruction fields and condition result, supplied by the datapath
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;

    // Single-bit strobes and selects
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic       ALUOp;

    // Two-bit selects
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;

    // Condition-gated write enables
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [1:0] FlagWrite;

    // Current controller state, for debug visibility
    logic [3:0] State;

    modport master (
        output Op, Funct, Rd, CondEx,
        input  IRWrite, AdrSrc, ALUSrcA, ALUOp,
        input  ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        input  PCWrite, RegWrite, MemWrite, FlagWrite,
        input  State
    );

    modport slave (
        input  Op, Funct, Rd, CondEx,
        output IRWrite, AdrSrc, ALUSrcA, ALUOp,
        output ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        output PCWrite, RegWrite, MemWrite, FlagWrite,
        output State
    );

endinterface

// File: rtl/imm_mc_ctrl.sv
// -----------------------------------------------------------------------------
// imm_mc_ctrl
// Multicycle controller for an ARM-like datapath. An eleven-state Moore FSM
// sequences each instruction through fetch, decode and a class-specific tail;
// the datapath strobes are decoded from the current state, and the write
// enables are gated by the condition result supplied with the instruction.
//
// Optional feature, selected at compile time:
//   IMM_MC_CTRL_CMPSKIP_EN  - when defined, compare/test instructions (which
//                             never write a register) return to FETCH straight
//                             from the execute state, giving a 3-cycle compare.
//                             When undefined they pass through ALUWB with the
//                             register write suppressed.
// -----------------------------------------------------------------------------
module imm_mc_ctrl (
    input  logic          clk,
    input  logic          reset,
    imm_mc_ctrl_if.slave  bus
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_UNDEF  = 2'b11;

    localparam logic [3:0] RD_PC     = 4'b1111;

    // -------------------------------------------------------------------------
    // Internal signals
    // -------------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;

    // Raw (ungated) controls from the main decoder
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic       alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;

    // Instruction-field derived terms
    logic       no_write;     // compare/test class: result discarded
    logic       cv_update;    // arithmetic command: C and V are meaningful
    logic       in_execute;   // currently in EXECUTER or EXECUTEI

    // -------------------------------------------------------------------------
    // Instruction field decode
    // -------------------------------------------------------------------------
    // TST/TEQ/CMP/CMN share cmd[3:2] = 10 and only update flags.
    assign no_write  = (bus.Op == OP_DP) && (bus.Funct[4:3] == 2'b10);

    // SUB, ADD, CMP, CMN produce carry and overflow; logical ops do not.
    assign cv_update = (bus.Funct[4:1] == 4'b0010) ||
                       (bus.Funct[4:1] == 4'b0100) ||
                       (bus.Funct[4:1] == 4'b1010) ||
                       (bus.Funct[4:1] == 4'b1011);

    assign in_execute = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);

    // -------------------------------------------------------------------------
    // State register: synchronous reset returns to FETCH from any state
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // Sequence is independent of CondEx so instruction length never changes
    // with the condition outcome; only the write enables are gated.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no
        // latch is inferred; unused encodings fall back to FETCH.
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_DP:     state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:    state_d = S_MEMADR;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_UNDEF:  state_d = S_UNKNOWN;
                    default:   state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:  state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXECUTER,
            S_EXECUTEI: begin
`ifdef IMM_MC_CTRL_CMPSKIP_EN
                state_d = no_write ? S_FETCH : S_ALUWB;
`else
                state_d = S_ALUWB;
`endif
            end
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_UNKNOWN: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // Main decoder: raw datapath controls as a function of the current state
    // -------------------------------------------------------------------------
    always_comb begin
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_op     = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        case (state_q)
            S_FETCH: begin
                // Read instruction at PC, compute PC+4 and write it back
                ir_write   = 1'b1;
                next_pc    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                // Compute PC+8 for use as R15 while registers are read
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: begin
                // Base plus immediate offset
                alu_src_b  = 2'b01;
            end
            S_MEMRD: begin
                adr_src    = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_b  = 2'b00;
                alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                alu_src_b  = 2'b01;
                alu_op     = 1'b1;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
            end
            S_BRANCH: begin
                // PC+8 plus branch offset, routed straight to the PC
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: begin
                // UNKNOWN and unused encodings drive nothing
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output drive: selects, condition-gated enables and flag update
    // -------------------------------------------------------------------------
    always_comb begin
        bus.IRWrite   = ir_write;
        bus.AdrSrc    = adr_src;
        bus.ALUSrcA   = alu_src_a;
        bus.ALUOp     = alu_op;
        bus.ALUSrcB   = alu_src_b;
        bus.ResultSrc = result_src;
        bus.State     = state_q;

        // Immediate format follows the instruction class; undefined uses 00
        bus.ImmSrc    = (bus.Op == OP_UNDEF) ? 2'b00 : bus.Op;

        // [0] reads R15 for branches, [1] reads Rd as store data
        bus.RegSrc    = {(bus.Op == OP_MEM), (bus.Op == OP_BRANCH)};

        // FETCH always advances the PC; a taken branch or a write to R15
        // redirects it
        bus.PCWrite   = next_pc |
                        (bus.CondEx & (branch | (reg_w & (bus.Rd == RD_PC))));
        bus.RegWrite  = reg_w & bus.CondEx & ~no_write;
        bus.MemWrite  = mem_w & bus.CondEx;

        // Flags only move during execute of an S-suffixed, passing instruction
        bus.FlagWrite = 2'b00;
        if (in_execute && bus.Funct[0] && bus.CondEx) begin
            bus.FlagWrite = {1'b1, cv_update};
        end
    end

endmodule

// File: tb/tb_imm_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imm_mc_ctrl
// Directed testbench for imm_mc_ctrl. Inputs change on the falling edge, and
// outputs are sampled 1 ns later, well away from the rising edge that moves
// the FSM. Each instruction is walked cycle by cycle against hand-derived
// states and write enables.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_imm_mc_ctrl;

    logic clk;
    logic reset;

    int checks;
    int errors;

    imm_mc_ctrl_if bus ();

    imm_mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply instruction fields; outputs settle before the next sample
    task automatic set_instr(input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input logic cond);
        bus.Op     = op;
        bus.Funct  = funct;
        bus.Rd     = rd;
        bus.CondEx = cond;
        #1;
    endtask

    // Check one cycle of an instruction, then move to the next sample point
    task automatic cyc(input string tag, input logic [3:0] st, input logic pcw,
                       input logic rw, input logic mw, input logic [1:0] fw);
        check($sformatf("%s.state", tag), 32'(bus.State),     32'(st));
        check($sformatf("%s.pcw",   tag), 32'(bus.PCWrite),   32'(pcw));
        check($sformatf("%s.rw",    tag), 32'(bus.RegWrite),  32'(rw));
        check($sformatf("%s.mw",    tag), 32'(bus.MemWrite),  32'(mw));
        check($sformatf("%s.fw",    tag), 32'(bus.FlagWrite), 32'(fw));
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'b0; bus.CondEx = 1'b0;

        // ---- Reset for one cycle, ADD immediate already presented ----------
        set_instr(2'b00, 6'b101000, 4'd1, 1'b1);
        @(negedge clk);
        #1;
        check("rst.state",   32'(bus.State),     32'd0);
        check("rst.irw",     32'(bus.IRWrite),   32'd1);
        check("rst.alusrcb", 32'(bus.ALUSrcB),   32'd2);
        check("rst.ressrc",  32'(bus.ResultSrc), 32'd2);
        check("rst.adrsrc",  32'(bus.AdrSrc),    32'd0);
        reset = 1'b0;

        // ---- ADD imm: 0,1,7,8 ---------------------------------------------
        check("add.imm", 32'(bus.ImmSrc), 32'd0);
        cyc("add.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("add.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        check("add.aluop", 32'(bus.ALUOp), 32'd1);
        check("add.srcb",  32'(bus.ALUSrcB), 32'd1);
        cyc("add.ei", 4'd7, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("add.wb", 4'd8, 1'b0, 1'b1, 1'b0, 2'b00);

        // ---- LDR to PC: 0,1,2,3,4 -----------------------------------------
        set_instr(2'b01, 6'b011001, 4'hF, 1'b1);
        check("ldr.imm",    32'(bus.ImmSrc), 32'd1);
        check("ldr.regsrc", 32'(bus.RegSrc), 32'd2);
        cyc("ldr.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("ldr.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("ldr.ma", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        check("ldr.adrsrc", 32'(bus.AdrSrc), 32'd1);
        cyc("ldr.mr", 4'd3, 1'b0, 1'b0, 1'b0, 2'b00);
        check("ldr.ressrc", 32'(bus.ResultSrc), 32'd1);
        cyc("ldr.wb", 4'd4, 1'b1, 1'b1, 1'b0, 2'b00);

        // ---- STR, condition failed: 0,1,2,5, no memory write --------------
        set_instr(2'b01, 6'b011000, 4'd2, 1'b0);
        cyc("str.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("str.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("str.ma", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("str.mw", 4'd5, 1'b0, 1'b0, 1'b0, 2'b00);

        // ---- STR, condition passed: memory write in MEMWR -----------------
        set_instr(2'b01, 6'b011000, 4'd2, 1'b1);
        cyc("strc.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("strc.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("strc.ma", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("strc.mw", 4'd5, 1'b0, 1'b0, 1'b1, 2'b00);

        // ---- Branch taken: 0,1,9 ------------------------------------------
        set_instr(2'b10, 6'b100000, 4'd0, 1'b1);
        check("b.imm",    32'(bus.ImmSrc), 32'd2);
        check("b.regsrc", 32'(bus.RegSrc), 32'd1);
        cyc("b.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("b.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("b.br", 4'd9, 1'b1, 1'b0, 1'b0, 2'b00);

        // ---- Branch not taken: same length, no PC write in BRANCH ---------
        set_instr(2'b10, 6'b100000, 4'd0, 1'b0);
        cyc("bn.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("bn.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("bn.br", 4'd9, 1'b0, 1'b0, 1'b0, 2'b00);

        // ---- CMP reg: flags 11, never a register write --------------------
        set_instr(2'b00, 6'b010101, 4'd0, 1'b1);
        cyc("cmp.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("cmp.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("cmp.er", 4'd6, 1'b0, 1'b0, 1'b0, 2'b11);
`ifndef IMM_MC_CTRL_CMPSKIP_EN
        cyc("cmp.wb", 4'd8, 1'b0, 1'b0, 1'b0, 2'b00);
`endif

        // ---- ANDS reg: logical op updates NZ only -------------------------
        set_instr(2'b00, 6'b000001, 4'd3, 1'b1);
        cyc("ands.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("ands.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("ands.er", 4'd6, 1'b0, 1'b0, 1'b0, 2'b10);
        cyc("ands.wb", 4'd8, 1'b0, 1'b1, 1'b0, 2'b00);

        // ---- ADDS reg, condition failed: no flags, no write ---------------
        set_instr(2'b00, 6'b001001, 4'd3, 1'b0);
        cyc("addn.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("addn.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("addn.er", 4'd6, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("addn.wb", 4'd8, 1'b0, 1'b0, 1'b0, 2'b00);

        // ---- MOV imm to PC: PC written from ALUWB -------------------------
        set_instr(2'b00, 6'b111010, 4'hF, 1'b1);
        cyc("movpc.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("movpc.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("movpc.ei", 4'd7, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("movpc.wb", 4'd8, 1'b1, 1'b1, 1'b0, 2'b00);

        // ---- Reset asserted while in MEMRD --------------------------------
        set_instr(2'b01, 6'b011001, 4'd4, 1'b1);
        cyc("ldrr.f",  4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cyc("ldrr.d",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("ldrr.ma", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        check("ldrr.mr.state", 32'(bus.State), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        check("ldrr.rst.irw", 32'(bus.IRWrite), 32'd1);
        cyc("ldrr.rst", 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        // Instruction restarts cleanly after the reset
        cyc("ldrr.d2",  4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("ldrr.ma2", 4'd2, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("ldrr.mr2", 4'd3, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("ldrr.wb2", 4'd4, 1'b0, 1'b1, 1'b0, 2'b00);

        // ---- Undefined: 0,1,10, back to FETCH -----------------------------
        set_instr(2'b11, 6'b000001, 4'hF, 1'b1);
        check("und.imm",    32'(bus.ImmSrc), 32'd0);
        check("und.regsrc", 32'(bus.RegSrc), 32'd0);
        cyc("und.f", 4'd0,  1'b1, 1'b0, 1'b0, 2'b00);
        cyc("und.d", 4'd1,  1'b0, 1'b0, 1'b0, 2'b00);
        cyc("und.u", 4'd10, 1'b0, 1'b0, 1'b0, 2'b00);
        check("und.back", 32'(bus.State), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
